serial_to_settings_rb: RTL and testbench

Parametrised serial-to-settings bridge with readback. Decodes an I2C-like, start/stop-framed serial stream from an asynchronous host (CPLD/MCU) into settings-bus writes. Also serves readback requests by shifting a register value back out on SDA. Sits between the board-level serial pins and the settings bus / readback mux of the radio core, and adds abort, timeout and error reporting.

---
 rtl/serial_to_settings_rb_pkg.sv | 27 ++
 rtl/serial_sync_edge.sv | 26 ++
 rtl/serial_to_settings_rb.sv | 194 +++++++++++++++++++
 tb/tb_serial_to_settings_rb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_to_settings_rb_pkg.sv
// Shared definitions for the serial-to-settings bridge:
// frame state encodings, R/W polarity and width helpers.
package serial_to_settings_rb_pkg;

  typedef enum logic [2:0] {
    S_SEARCH  = 3'd0,
    S_ADDRESS = 3'd1,
    S_RW      = 3'd2,
    S_WDATA   = 3'd3,
    S_RDATA   = 3'd4,
    S_STOP1   = 3'd5,
    S_STOP2   = 3'd6
  } state_t;

  localparam logic RW_READ = 1'b1;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_w(input int a, input int b);
    int m;
    m = max_i(a, b);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/serial_sync_edge.sv
// Three-flop synchronizer for an async pin with
// edge outputs taken from the settled stages 2 and 3.
module serial_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic s,
  output logic s2,
  output logic rise,
  output logic fall
);

  logic [2:0] st;

  // Resets high to match an idle open-drain bus.
  always_ff @(posedge clk) begin
    if (reset) st <= 3'b111;
    else       st <= {st[1:0], d};
  end

  assign s    = st[1];
  assign s2   = st[2];
  assign rise = s & ~s2;
  assign fall = ~s & s2;

endmodule

// File: rtl/serial_to_settings_rb.sv
// Start/stop framed serial stream to settings-bus writes,
// with register readback shifted out on SDA.
module serial_to_settings_rb
  import serial_to_settings_rb_pkg::*;
#(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl,
  input  logic              sda,
  output logic              sda_out,
  output logic              sda_oe,
  output logic              set_stb,
  output logic [AWIDTH-1:0] set_addr,
  output logic [DWIDTH-1:0] set_data,
  output logic              rd_stb,
  input  logic [DWIDTH-1:0] rb_data,
  output logic              frame_err,
  output logic [31:0]       debug
);

  localparam int CW   = cnt_w(AWIDTH, DWIDTH);
  localparam int TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int DBGW = CW + 5;
  localparam logic [CW-1:0] A_LAST = CW'(AWIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DWIDTH - 1);

  logic scl_s, scl_s2, scl_rise, scl_fall;
  logic sda_s, sda_s2, sda_rise, sda_fall;

  serial_sync_edge u_scl (
    .clk   (clk),
    .reset (reset),
    .d     (scl),
    .s     (scl_s),
    .s2    (scl_s2),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  serial_sync_edge u_sda (
    .clk   (clk),
    .reset (reset),
    .d     (sda),
    .s     (sda_s),
    .s2    (sda_s2),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [TW-1:0]     tcnt;
  logic [DWIDTH-1:0] shift;
  logic              is_read;
  logic              rd_dly;

  logic start, stop, tmo;
  logic shift_a, shift_d, drive, rd_req;
  logic err, stb, quiet;

  assign start = scl_s & scl_s2 & sda_fall;
  assign stop  = scl_s & scl_s2 & sda_rise;
  assign tmo   = (TIMEOUT != 0) && (state != S_SEARCH)
              && (tcnt == TW'(TIMEOUT));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_a = 1'b0;
    shift_d = 1'b0;
    drive   = 1'b0;
    rd_req  = 1'b0;
    err     = 1'b0;
    stb     = 1'b0;
    quiet   = 1'b0;
    if (start) begin
      state_n = S_ADDRESS;
      cnt_n   = '0;
      if (state != S_SEARCH) begin
        err   = 1'b1;
        quiet = 1'b1;
      end
    end else if (stop && state != S_SEARCH) begin
      state_n = S_SEARCH;
      quiet   = 1'b1;
      if (state == S_STOP2) stb = ~is_read;
      else                  err = 1'b1;
    end else if (tmo) begin
      state_n = S_SEARCH;
      err     = 1'b1;
      quiet   = 1'b1;
    end else begin
      unique case (state)
        S_SEARCH: begin
        end
        S_ADDRESS: if (scl_rise) begin
          shift_a = 1'b1;
          if (cnt == A_LAST) begin
            state_n = S_RW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_RW: if (scl_rise) begin
          cnt_n = '0;
          if (sda_s == RW_READ) begin
            state_n = S_RDATA;
            rd_req  = 1'b1;
          end else begin
            state_n = S_WDATA;
          end
        end
        S_WDATA: if (scl_rise) begin
          shift_d = 1'b1;
          if (cnt == D_LAST) begin
            state_n = S_STOP1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_RDATA: if (scl_fall) begin
          drive = 1'b1;
          if (cnt == D_LAST) begin
            state_n = S_STOP1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_STOP1: if (scl_rise) state_n = S_STOP2;
        S_STOP2: begin
        end
        default: state_n = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_SEARCH;
      cnt       <= '0;
      set_addr  <= '0;
      set_data  <= '0;
      shift     <= '0;
      is_read   <= 1'b0;
      set_stb   <= 1'b0;
      rd_stb    <= 1'b0;
      rd_dly    <= 1'b0;
      frame_err <= 1'b0;
      sda_out   <= 1'b1;
      sda_oe    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      set_stb   <= stb;
      rd_stb    <= rd_req;
      rd_dly    <= rd_stb;
      frame_err <= err;
      if (shift_a) set_addr <= {set_addr[AWIDTH-2:0], sda_s};
      if (shift_d) set_data <= {set_data[DWIDTH-2:0], sda_s};
      if (rd_req)     is_read <= 1'b1;
      else if (start) is_read <= 1'b0;
      // Readback mux answers one cycle after the request.
      if (rd_dly)     shift <= rb_data;
      else if (drive) shift <= {shift[DWIDTH-2:0], 1'b0};
      if (drive) begin
        sda_out <= shift[DWIDTH-1];
        sda_oe  <= 1'b1;
      end else if (quiet || (scl_fall && state != S_RDATA)) begin
        sda_out <= 1'b1;
        sda_oe  <= 1'b0;
      end
    end
  end

  // Idle counter, held clear while hunting for a START.
  always_ff @(posedge clk) begin
    if (reset)
      tcnt <= '0;
    else if (scl_rise || scl_fall || start || state == S_SEARCH)
      tcnt <= '0;
    else if (tcnt != '1)
      tcnt <= tcnt + TW'(1);
  end

  assign debug = {{(32-DBGW){1'b0}}, cnt, state, scl_s, sda_s};

endmodule

// File: tb/tb_serial_to_settings_rb.sv
// Directed bench: bit-banged host frames into a narrow
// (8/32, short timeout) and a wide (16/64) bridge.
module tb_serial_to_settings_rb;

  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic scl, sda, sel;
  logic a_scl, a_sda, b_scl, b_sda;

  logic        a_sda_out, a_sda_oe, a_set_stb, a_rd_stb, a_frame_err;
  logic [7:0]  a_set_addr;
  logic [31:0] a_set_data, a_rb_data, a_debug;

  logic        b_sda_out, b_sda_oe, b_set_stb, b_rd_stb, b_frame_err;
  logic [15:0] b_set_addr;
  logic [63:0] b_set_data, b_rb_data;
  logic [31:0] b_debug;

  int n_vec = 0;
  int n_err = 0;

  int a_stb_n = 0, a_rd_n = 0, a_err_n = 0;
  int b_stb_n = 0, b_err_n = 0;
  logic [7:0]  a_cap_addr, a_rd_addr;
  logic [31:0] a_cap_data;
  logic [15:0] b_cap_addr;
  logic [63:0] b_cap_data;

  always #5 clk = ~clk;

  assign a_scl = sel ? 1'b1 : scl;
  assign a_sda = sel ? 1'b1 : sda;
  assign b_scl = sel ? scl : 1'b1;
  assign b_sda = sel ? sda : 1'b1;

  serial_to_settings_rb #(
    .AWIDTH(8), .DWIDTH(32), .TIMEOUT(100)
  ) u_a (
    .clk(clk), .reset(rst_a), .scl(a_scl), .sda(a_sda),
    .sda_out(a_sda_out), .sda_oe(a_sda_oe),
    .set_stb(a_set_stb), .set_addr(a_set_addr),
    .set_data(a_set_data), .rd_stb(a_rd_stb),
    .rb_data(a_rb_data), .frame_err(a_frame_err),
    .debug(a_debug)
  );

  serial_to_settings_rb #(
    .AWIDTH(16), .DWIDTH(64), .TIMEOUT(1000)
  ) u_b (
    .clk(clk), .reset(rst_b), .scl(b_scl), .sda(b_sda),
    .sda_out(b_sda_out), .sda_oe(b_sda_oe),
    .set_stb(b_set_stb), .set_addr(b_set_addr),
    .set_data(b_set_data), .rd_stb(b_rd_stb),
    .rb_data(b_rb_data), .frame_err(b_frame_err),
    .debug(b_debug)
  );

  always @(negedge clk) begin
    if (a_set_stb) begin
      a_stb_n++;
      a_cap_addr = a_set_addr;
      a_cap_data = a_set_data;
    end
    if (a_rd_stb) begin
      a_rd_n++;
      a_rd_addr = a_set_addr;
    end
    if (a_frame_err) a_err_n++;
    if (b_set_stb) begin
      b_stb_n++;
      b_cap_addr = b_set_addr;
      b_cap_data = b_set_data;
    end
    if (b_frame_err) b_err_n++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    sda = 1'b1; tick(2);
    scl = 1'b1; tick(H);
    sda = 1'b0; tick(H);
    scl = 1'b0; tick(2);
  endtask

  task automatic do_stop();
    sda = 1'b0; tick(H);
    scl = 1'b1; tick(H);
    sda = 1'b1; tick(H);
  endtask

  task automatic send_bit(input logic b);
    sda = b;    tick(H);
    scl = 1'b1; tick(H);
    scl = 1'b0; tick(2);
  endtask

  task automatic send(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic write_frame(input logic [63:0] ad, input int aw,
                             input logic [63:0] dt, input int dw);
    do_start();
    send(ad, aw);
    send_bit(1'b0);
    send(dt, dw);
    send_bit(1'b0);
    do_stop();
  endtask

  task automatic read_bits(input int n, output logic [31:0] got,
                           output int oe_hi);
    got = '0;
    oe_hi = 0;
    for (int i = 0; i < n; i++) begin
      sda = 1'b1; tick(H);
      scl = 1'b1;
      got = {got[30:0], a_sda_out};
      if (a_sda_oe) oe_hi++;
      tick(H);
      scl = 1'b0; tick(2);
    end
  endtask

  initial begin
    logic [31:0] got;
    int oe_hi, stb0, err0, rd0;
    sel = 1'b0; scl = 1'b1; sda = 1'b1;
    rst_a = 1'b1; rst_b = 1'b1;
    a_rb_data = 32'hCAFEF00D;
    b_rb_data = '0;
    tick(5);
    rst_a = 1'b0; rst_b = 1'b0;
    tick(5);

    check("rst_sda_out", a_sda_out, 1'b1);
    check("rst_sda_oe", a_sda_oe, 1'b0);
    check("rst_addr", a_set_addr, 8'h00);
    check("rst_data", a_set_data, 32'h0);
    check("rst_debug", a_debug, 32'h3);
    check("rst_pulses", a_stb_n + a_rd_n + a_err_n, 0);

    write_frame(64'h5A, 8, 64'hDEADBEEF, 32);
    check("wr_stb_n", a_stb_n, 1);
    check("wr_addr", a_cap_addr, 8'h5A);
    check("wr_data", a_cap_data, 32'hDEADBEEF);
    check("wr_err_n", a_err_n, 0);

    do_start();
    send(64'h12, 8);
    send_bit(1'b1);
    read_bits(32, got, oe_hi);
    check("rd_rd_n", a_rd_n, 1);
    check("rd_addr", a_rd_addr, 8'h12);
    check("rd_data", got, 32'hCAFEF00D);
    check("rd_oe_bits", oe_hi, 32);
    sda = 1'b0; tick(H);
    check("rd_oe_release", a_sda_oe, 1'b0);
    send_bit(1'b0);
    do_stop();
    check("rd_no_stb", a_stb_n, 1);
    check("rd_err_n", a_err_n, 0);

    do_start();
    send(64'h77, 8);
    send_bit(1'b0);
    send(64'h3FF, 10);
    do_stop();
    check("abort_err_n", a_err_n, 1);
    check("abort_no_stb", a_stb_n, 1);
    write_frame(64'h01, 8, 64'h1, 32);
    check("post_stb_n", a_stb_n, 2);
    check("post_addr", a_cap_addr, 8'h01);
    check("post_data", a_cap_data, 32'h1);

    do_start();
    send(64'hC, 4);
    write_frame(64'hA5, 8, 64'h12345678, 32);
    check("rst_err_n", a_err_n, 2);
    check("rst_stb_n", a_stb_n, 3);
    check("rst_addr2", a_cap_addr, 8'hA5);
    check("rst_data2", a_cap_data, 32'h12345678);

    rd0 = a_rd_n;
    do_start();
    send(64'h33, 8);
    send_bit(1'b1);
    read_bits(4, got, oe_hi);
    check("to_oe_before", a_sda_oe, 1'b1);
    tick(120);
    check("to_err_n", a_err_n, 3);
    check("to_state", a_debug[4:2], 3'd0);
    check("to_oe", a_sda_oe, 1'b0);
    check("to_rd_n", a_rd_n, rd0 + 1);
    scl = 1'b1; sda = 1'b1; tick(H);

    stb0 = a_stb_n;
    err0 = a_err_n;
    sel = 1'b1;
    tick(4);
    write_frame(64'hBEEF, 16, 64'h0123456789ABCDEF, 64);
    check("w_stb_n", b_stb_n, 1);
    check("w_addr", b_cap_addr, 16'hBEEF);
    check("w_data", b_cap_data, 64'h0123456789ABCDEF);
    check("w_err_n", b_err_n, 0);

    do_start();
    send(64'h1234, 16);
    send_bit(1'b0);
    send(64'h5, 4);
    rst_b = 1'b1;
    tick(3);
    check("mr_addr", b_set_addr, 16'h0);
    check("mr_data", b_set_data, 64'h0);
    check("mr_oe", b_sda_oe, 1'b0);
    check("mr_sda_out", b_sda_out, 1'b1);
    check("mr_strobes", {b_set_stb, b_rd_stb, b_frame_err}, 3'b000);
    check("mr_debug", b_debug, 32'h3);
    scl = 1'b1; sda = 1'b1;
    tick(4);
    rst_b = 1'b0;
    sel = 1'b0;
    tick(8);
    check("a_quiet", a_stb_n + a_err_n, stb0 + err0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
